// File: rtl/decode_issue_if.sv
// decode_issue_if: fetch, regfile, writeback and EX signals of the decode/issue stage.
// master = decode stage side, slave = surrounding pipeline / environment side.
interface decode_issue_if #(parameter int XLEN = 32);
   logic            flush;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic [4:0]      rf_a1;
   logic [4:0]      rf_a2;
   logic [XLEN-1:0] rf_rd1;
   logic [XLEN-1:0] rf_rd2;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ex_valid;
   logic            ex_ready;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_instr;
   logic [XLEN-1:0] ex_rs1_val;
   logic [XLEN-1:0] ex_rs2_val;
   logic [4:0]      ex_rd;
   logic            ex_we;
   modport master (
      input  flush, if_valid, if_instr, if_pc, rf_rd1, rf_rd2, wb_valid, wb_rd, wb_data, ex_ready,
      output if_ready, rf_a1, rf_a2, ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd, ex_we
   );
   modport slave (
      output flush, if_valid, if_instr, if_pc, rf_rd1, rf_rd2, wb_valid, wb_rd, wb_data, ex_ready,
      input  if_ready, rf_a1, rf_a2, ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd, ex_we
   );
endinterface

// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage with a RAW scoreboard and one output register.
// Define FWD_WB_EN to forward the retiring writeback value into a stalled source operand.
module decode_issue #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input logic           clk,
   input logic           rst,
   decode_issue_if.master bus
);
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;

   logic [6:0]      opc;
   logic [4:0]      rs1, rs2, rd;
   logic            uses_rs1, uses_rs2, writes_rd, we;
   logic            fwd1, fwd2, hz1, hz2, accept;
   logic [XLEN-1:0] op1, op2;
   logic [NREG-1:0] busy, set_mask, clr_mask;

   assign opc       = bus.if_instr[6:0];
   assign rd        = bus.if_instr[11:7];
   assign rs1       = bus.if_instr[19:15];
   assign rs2       = bus.if_instr[24:20];
   assign bus.rf_a1 = rs1;
   assign bus.rf_a2 = rs2;

   always_comb begin
      uses_rs1  = opc inside {OP, OP_IMM, LOAD, STORE, BRANCH, JALR};
      uses_rs2  = opc inside {OP, STORE, BRANCH};
      writes_rd = opc inside {OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR};
   end

`ifdef FWD_WB_EN
   // a busy source being retired this very cycle is satisfied by wb_data
   assign fwd1 = uses_rs1 & busy[rs1] & bus.wb_valid & (bus.wb_rd == rs1);
   assign fwd2 = uses_rs2 & busy[rs2] & bus.wb_valid & (bus.wb_rd == rs2);
   assign op1  = fwd1 ? bus.wb_data : bus.rf_rd1;
   assign op2  = fwd2 ? bus.wb_data : bus.rf_rd2;
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
   assign op1  = bus.rf_rd1;
   assign op2  = bus.rf_rd2;
`endif

   assign hz1          = uses_rs1 & (rs1 != 5'd0) & busy[rs1] & ~fwd1;
   assign hz2          = uses_rs2 & (rs2 != 5'd0) & busy[rs2] & ~fwd2;
   assign bus.if_ready = ~rst & (~bus.ex_valid | bus.ex_ready) & ~(hz1 | hz2);
   assign accept       = bus.if_valid & bus.if_ready & ~bus.flush;
   assign we           = writes_rd & (rd != 5'd0);

   // set is OR-ed after clear so a new producer outlives an older one retiring
   assign set_mask = (accept & we) ? NREG'(1) << rd : '0;
   assign clr_mask = (bus.wb_valid & (bus.wb_rd != 5'd0)) ? NREG'(1) << bus.wb_rd : '0;

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= (busy & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ex_valid   <= 1'b0;
         bus.ex_pc      <= '0;
         bus.ex_instr   <= '0;
         bus.ex_rs1_val <= '0;
         bus.ex_rs2_val <= '0;
         bus.ex_rd      <= '0;
         bus.ex_we      <= 1'b0;
      end else if (accept) begin
         bus.ex_valid   <= 1'b1;
         bus.ex_pc      <= bus.if_pc;
         bus.ex_instr   <= bus.if_instr;
         bus.ex_rs1_val <= op1;
         bus.ex_rs2_val <= op2;
         bus.ex_rd      <= writes_rd ? rd : 5'd0;
         bus.ex_we      <= we;
      end else if (bus.ex_ready) begin
         bus.ex_valid   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed scenarios plus randomized traffic for decode_issue, checked against
// an opcode-table scoreboard model; honours FWD_WB_EN like the design.
module tb_decode_issue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_issue_if bus ();
   decode_issue dut (.clk(clk), .rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;

   logic [31:0] rf [32] = '{default: 32'h0};
   assign bus.rf_rd1 = (bus.rf_a1 == 5'd0) ? 32'h0 : rf[bus.rf_a1];
   assign bus.rf_rd2 = (bus.rf_a2 == 5'd0) ? 32'h0 : rf[bus.rf_a2];
   always @(posedge clk) if (bus.wb_valid && bus.wb_rd != 5'd0) rf[bus.wb_rd] <= bus.wb_data;

   logic        m_valid, m_we;
   logic [31:0] m_pc, m_instr, m_v1, m_v2, mbusy;
   logic [4:0]  m_rd;

   // {reads rs1, reads rs2, writes rd} per opcode
   function automatic logic [2:0] usage(input logic [6:0] opc);
      case (opc)
         7'h33:               return 3'b111;
         7'h13, 7'h03, 7'h67: return 3'b101;
         7'h23, 7'h63:        return 3'b110;
         7'h37, 7'h17, 7'h6f: return 3'b001;
         default:             return 3'b000;
      endcase
   endfunction

   function automatic bit src_fwd(input bit used, input logic [4:0] r);
`ifdef FWD_WB_EN
      return used && r != 5'd0 && mbusy[r] && bus.wb_valid && bus.wb_rd == r;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit src_hz(input bit used, input logic [4:0] r);
      return used && r != 5'd0 && mbusy[r] && !src_fwd(used, r);
   endfunction

   function automatic logic [31:0] rf_val(input logic [4:0] r);
      return (r == 5'd0) ? 32'h0 : rf[r];
   endfunction

   function automatic bit m_ready();
      logic [2:0] u;
      u = usage(bus.if_instr[6:0]);
      return !rst && (!m_valid || bus.ex_ready) && !src_hz(u[2], bus.if_instr[19:15])
             && !src_hz(u[1], bus.if_instr[24:20]);
   endfunction

   always @(posedge clk) begin
      logic [2:0]  u;
      logic [4:0]  r1, r2, d;
      logic [31:0] nb;
      if (rst) begin
         m_valid <= 1'b0; m_pc <= '0; m_instr <= '0; m_v1 <= '0; m_v2 <= '0;
         m_rd <= '0; m_we <= 1'b0; mbusy <= '0;
      end else begin
         u  = usage(bus.if_instr[6:0]);
         r1 = bus.if_instr[19:15];
         r2 = bus.if_instr[24:20];
         d  = bus.if_instr[11:7];
         nb = mbusy;
         if (bus.wb_valid && bus.wb_rd != 5'd0) nb[bus.wb_rd] = 1'b0;
         if (bus.if_valid && !bus.flush && m_ready()) begin
            m_valid <= 1'b1;
            m_pc    <= bus.if_pc;
            m_instr <= bus.if_instr;
            m_v1    <= src_fwd(u[2], r1) ? bus.wb_data : rf_val(r1);
            m_v2    <= src_fwd(u[1], r2) ? bus.wb_data : rf_val(r2);
            m_rd    <= u[0] ? d : 5'd0;
            m_we    <= u[0] && d != 5'd0;
            if (u[0] && d != 5'd0) nb[d] = 1'b1;
         end else if (bus.ex_ready) begin
            m_valid <= 1'b0;
         end
         mbusy <= nb;
      end
   end

   function automatic logic [31:0] addi(input logic [4:0] d, input logic [4:0] s, input logic [11:0] imm);
      return {imm, s, 3'b000, d, 7'h13};
   endfunction
   function automatic logic [31:0] add(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
      return {7'h00, s2, s1, 3'b000, d, 7'h33};
   endfunction
   function automatic logic [31:0] sw(input logic [4:0] s2, input logic [4:0] s1);
      return {7'h00, s2, s1, 3'b010, 5'h00, 7'h23};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.if_valid = 1'b0; bus.flush = 1'b0; bus.if_instr = '0; bus.if_pc = '0;
      bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.ex_ready = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      bus.if_valid = 1'b1;
      bus.if_instr = addi(5'd1, 5'd0, 12'd5);
      repeat (2) begin
         tick();
         tests++;
         if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL reset_if_ready: got %b want 0", bus.if_ready); end
      end
      tests++;
      if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid); end
      tests++;
      if (dut.busy !== 32'h0) begin fails++; $display("FAIL reset_busy: got %h want 0", dut.busy); end
      rst = 1'b0;
      #1;
      tests++;
      if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", bus.if_ready); end
      tick();
      tests++;
      if ({bus.ex_valid, dut.busy} !== {1'b1, 32'h2}) begin
         fails++; $display("FAIL reset_first_issue: got valid=%b busy=%h want 1/00000002", bus.ex_valid, dut.busy);
      end
      rst = 1'b1;
      tick();
      tests++;
      if ({bus.ex_valid, bus.ex_we, bus.ex_rd, bus.ex_pc, dut.busy} !== '0) begin
         fails++; $display("FAIL reset_mid_op: got valid=%b we=%b rd=%0d pc=%h busy=%h want all 0",
                           bus.ex_valid, bus.ex_we, bus.ex_rd, bus.ex_pc, dut.busy);
      end
      rst = 1'b0;
      idle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.if_valid = 1'b1;
      bus.if_instr = addi(5'd1, 5'd0, 12'd5);
      bus.if_pc    = 32'h100;
      #1;
      tests++;
      if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %b want 1", bus.if_ready); end
      tick();
      tests++;
      if ({bus.ex_valid, bus.ex_rd, bus.ex_we, bus.ex_pc, bus.ex_rs1_val} !== {1'b1, 5'd1, 1'b1, 32'h100, 32'h0}) begin
         fails++; $display("FAIL b2b_first: got valid=%b rd=%0d we=%b pc=%h rs1=%h want 1/1/1/100/0",
                           bus.ex_valid, bus.ex_rd, bus.ex_we, bus.ex_pc, bus.ex_rs1_val);
      end
      bus.if_instr = addi(5'd2, 5'd0, 12'd7);
      bus.if_pc    = 32'h104;
      #1;
      tests++;
      if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready2: got %b want 1", bus.if_ready); end
      tick();
      tests++;
      if ({bus.ex_valid, bus.ex_rd, bus.ex_pc} !== {1'b1, 5'd2, 32'h104}) begin
         fails++; $display("FAIL b2b_second: got valid=%b rd=%0d pc=%h want 1/2/104", bus.ex_valid, bus.ex_rd, bus.ex_pc);
      end
      tests++;
      if (dut.busy[2:1] !== 2'b11) begin fails++; $display("FAIL b2b_busy: got %b want 11", dut.busy[2:1]); end
      idle();
      tick();
      tests++;
      if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", bus.ex_valid); end
   endtask

   task automatic test_raw();
      logic [31:0] dep;
      dep = add(5'd4, 5'd3, 5'd3);
      do_reset();
      bus.if_valid = 1'b1;
      bus.if_instr = addi(5'd3, 5'd0, 12'd1);
      bus.if_pc    = 32'h200;
      tick();
      bus.if_instr = dep;
      bus.if_pc    = 32'h204;
      repeat (3) begin
         #1;
         tests++;
         if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL raw_stall: got if_ready=%b want 0", bus.if_ready); end
         tick();
      end
      tests++;
      if (bus.ex_valid !== 1'b0) begin fails++; $display("FAIL raw_bubble: got ex_valid=%b want 0", bus.ex_valid); end
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd3;
      bus.wb_data  = 32'd1;
      #1;
`ifdef FWD_WB_EN
      tests++;
      if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL raw_fwd_ready: got %b want 1", bus.if_ready); end
      tick();
      idle();
`else
      tests++;
      if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL raw_wb_cycle_ready: got %b want 0", bus.if_ready); end
      tick();
      bus.wb_valid = 1'b0;
      #1;
      tests++;
      if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL raw_after_wb_ready: got %b want 1", bus.if_ready); end
      tick();
      idle();
`endif
      tests++;
      if ({bus.ex_valid, bus.ex_instr, bus.ex_rs1_val, bus.ex_rs2_val} !== {1'b1, dep, 32'd1, 32'd1}) begin
         fails++; $display("FAIL raw_issue: got valid=%b instr=%h rs1=%h rs2=%h want 1/%h/1/1",
                           bus.ex_valid, bus.ex_instr, bus.ex_rs1_val, bus.ex_rs2_val, dep);
      end
      tests++;
      if (dut.busy[4:3] !== 2'b10) begin fails++; $display("FAIL raw_busy: got %b want 10", dut.busy[4:3]); end
   endtask

   task automatic test_backpressure();
      logic [31:0] i1, i2;
      i1 = addi(5'd1, 5'd0, 12'd5);
      i2 = addi(5'd2, 5'd0, 12'd7);
      do_reset();
      bus.if_valid = 1'b1;
      bus.if_instr = i1;
      bus.if_pc    = 32'h300;
      tick();
      bus.ex_ready = 1'b0;
      bus.if_instr = i2;
      bus.if_pc    = 32'h304;
      repeat (4) begin
         #1;
         tests++;
         if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL bp_ready: got %b want 0", bus.if_ready); end
         tick();
         tests++;
         if ({bus.ex_valid, bus.ex_pc, bus.ex_instr, bus.ex_rd, bus.ex_we} !== {1'b1, 32'h300, i1, 5'd1, 1'b1}) begin
            fails++; $display("FAIL bp_hold: got valid=%b pc=%h instr=%h rd=%0d we=%b want 1/300/%h/1/1",
                              bus.ex_valid, bus.ex_pc, bus.ex_instr, bus.ex_rd, bus.ex_we, i1);
         end
      end
      bus.ex_ready = 1'b1;
      #1;
      tests++;
      if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", bus.if_ready); end
      tick();
      tests++;
      if ({bus.ex_valid, bus.ex_pc, bus.ex_instr} !== {1'b1, 32'h304, i2}) begin
         fails++; $display("FAIL bp_next_issue: got valid=%b pc=%h instr=%h want 1/304/%h",
                           bus.ex_valid, bus.ex_pc, bus.ex_instr, i2);
      end
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      bus.if_valid = 1'b1;
      bus.if_instr = addi(5'd1, 5'd0, 12'd5);
      tick();
      idle();
      tick();
      bus.if_valid = 1'b1;
      bus.flush    = 1'b1;
      bus.if_instr = sw(5'd5, 5'd6);
      tick();
      tests++;
      if ({bus.ex_valid, dut.busy} !== {1'b0, 32'h2}) begin
         fails++; $display("FAIL flush_sw: got valid=%b busy=%h want 0/00000002", bus.ex_valid, dut.busy);
      end
      bus.if_instr = addi(5'd8, 5'd0, 12'd1);
      tick();
      tests++;
      if ({bus.ex_valid, dut.busy} !== {1'b0, 32'h2}) begin
         fails++; $display("FAIL flush_addi: got valid=%b busy=%h want 0/00000002", bus.ex_valid, dut.busy);
      end
      idle();
   endtask

   task automatic test_collision();
      do_reset();
      bus.if_valid = 1'b1;
      bus.if_instr = addi(5'd7, 5'd0, 12'd1);
      tick();
      bus.if_instr = addi(5'd7, 5'd0, 12'd2);
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd7;
      bus.wb_data  = 32'd1;
      #1;
      tests++;
      if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL coll_ready: got %b want 1", bus.if_ready); end
      tick();
      idle();
      tests++;
      if (dut.busy[7] !== 1'b1) begin fails++; $display("FAIL coll_set_wins: got busy7=%b want 1", dut.busy[7]); end
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd7;
      tick();
      idle();
      tests++;
      if (dut.busy[7] !== 1'b0) begin fails++; $display("FAIL coll_clear: got busy7=%b want 0", dut.busy[7]); end
   endtask

   task automatic test_random();
      logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h17, 7'h6f, 7'h0b};
      logic [31:0] ins;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         ins         = $urandom;
         ins[6:0]    = ops[$urandom_range(0, 9)];
         ins[11:7]   = 5'($urandom_range(0, 7));
         ins[19:15]  = 5'($urandom_range(0, 7));
         ins[24:20]  = 5'($urandom_range(0, 7));
         bus.if_instr = ins;
         bus.if_pc    = 32'(c * 4);
         bus.if_valid = $urandom_range(0, 9) < 8;
         bus.flush    = $urandom_range(0, 9) == 0;
         bus.ex_ready = $urandom_range(0, 9) < 7;
         bus.wb_valid = $urandom_range(0, 2) == 0;
         bus.wb_rd    = 5'($urandom_range(0, 7));
         bus.wb_data  = $urandom;
         #1;
         tests++;
         if (bus.if_ready !== m_ready()) begin
            fails++; $display("FAIL rand_ready c=%0d: got %b want %b", c, bus.if_ready, m_ready());
         end
         tick();
         tests++;
         if ({bus.ex_valid, bus.ex_pc, bus.ex_instr, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_rd, bus.ex_we}
             !== {m_valid, m_pc, m_instr, m_v1, m_v2, m_rd, m_we}) begin
            fails++; $display("FAIL rand_ex c=%0d: got v=%b pc=%h i=%h a=%h b=%h rd=%0d we=%b want v=%b pc=%h i=%h a=%h b=%h rd=%0d we=%b",
                              c, bus.ex_valid, bus.ex_pc, bus.ex_instr, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_rd, bus.ex_we,
                              m_valid, m_pc, m_instr, m_v1, m_v2, m_rd, m_we);
         end
         tests++;
         if (dut.busy !== mbusy) begin fails++; $display("FAIL rand_busy c=%0d: got %h want %h", c, dut.busy, mbusy); end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_back_to_back();
      test_raw();
      test_backpressure();
      test_flush();
      test_collision();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
